gate_output_filter: RTL

GATE_OUTPUT_FILTER -- requirements
Module: gate_output_filter

---
 rtl/gate_output_filter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gate_output_filter.sv
// Synchronises and debounces an asynchronous gate result, then reports accepted
// edges as strobes, a pending event with acknowledge handshake, and an edge count.
module gate_output_filter #(
    parameter int SyncStages   = 2,
    parameter int FilterLength = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Tick,
    input  logic       Gate_In,
    input  logic       Ack,
    input  logic       Count_Clear,
    output logic       Filtered,
    output logic       Rise_Pulse,
    output logic       Fall_Pulse,
    output logic       Event_Valid,
    output logic       Event_Type,
    output logic [7:0] Event_Count,
    output logic       Overflow
);

    localparam logic [1:0] LOW       = 2'd0;
    localparam logic [1:0] QUAL_HIGH = 2'd1;
    localparam logic [1:0] HIGH      = 2'd2;
    localparam logic [1:0] QUAL_LOW  = 2'd3;

    localparam logic [3:0] CntLast = 4'(FilterLength - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  s;
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  filtered_d;
    logic                  rise_d, fall_d;
    logic                  accept;

    // The synchroniser runs every cycle so the filter always sees a settled sample.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], Gate_In};
        end
    end

    assign s = sync_q[SyncStages-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        filtered_d = Filtered;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (Tick) begin
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_d = QUAL_HIGH;
                        cnt_d   = 4'd1;
                    end
                end
                QUAL_HIGH: begin
                    if (!s) begin
                        state_d = LOW;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == CntLast) begin
                        state_d    = HIGH;
                        cnt_d      = 4'd0;
                        filtered_d = 1'b1;
                        rise_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_d = QUAL_LOW;
                        cnt_d   = 4'd1;
                    end
                end
                QUAL_LOW: begin
                    if (s) begin
                        state_d = HIGH;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == CntLast) begin
                        state_d    = LOW;
                        cnt_d      = 4'd0;
                        filtered_d = 1'b0;
                        fall_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign accept = rise_d | fall_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= LOW;
            cnt_q      <= 4'd0;
            Filtered   <= 1'b0;
            Rise_Pulse <= 1'b0;
            Fall_Pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            Filtered   <= filtered_d;
            Rise_Pulse <= rise_d;
            Fall_Pulse <= fall_d;
        end
    end

    // A new edge always wins over Ack; it only counts as lost when nobody consumed the old one.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Event_Valid <= 1'b0;
            Event_Type  <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            if (accept) begin
                Event_Valid <= 1'b1;
                Event_Type  <= rise_d;
                if (Event_Valid && !Ack) begin
                    Overflow <= 1'b1;
                end
            end else if (Ack) begin
                Event_Valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Event_Count <= 8'd0;
        end else if (Count_Clear) begin
            Event_Count <= 8'd0;
        end else if (accept) begin
            Event_Count <= Event_Count + 8'd1;
        end
    end

endmodule
